issue_scheduler: RTL and testbench

//  Buffers decoded operation_t words and issues them one at a time to the execute stage.

---
 rtl/issue_scheduler_pkg.sv | 14 +
 rtl/issue_scheduler.sv | 171 +++++++++++++++++
 tb/tb_issue_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared operation word layout between decode, the issue scheduler and execute.
package issue_scheduler_pkg;

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_MEM    = 2'd1;
  localparam logic [1:0] OP_BRANCH = 2'd2;
  // 2'd3 is not a legal operation type; such ops are dropped at issue.

  typedef struct packed {
    logic [1:0]  op_type;
    logic [13:0] payload;
  } operation_t;

endpackage

// File: rtl/issue_scheduler.sv
// In-order issue buffer between decode and execute. Ops are issued one at a time;
// MEM ops hold issue until mem_done (or timeout), BRANCH ops hold issue until the
// branch resolves, and a taken branch discards every younger buffered op.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  operation_t               in_op,
  output logic                     issue_valid,
  output operation_t               issue_op,
  input  logic                     mem_done,
  input  logic                     branch_resolved,
  input  logic                     branch_taken,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_timeout,
  output logic                     err_unknown
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] ST_ISSUE    = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_BR_WAIT  = 2'd2;

  operation_t             buffer [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]       rd_ptr, rd_ptr_next;
  logic [OCC_W-1:0]       count, count_next;
  logic [1:0]             state, state_next;
  logic [CNT_W-1:0]       tmo_cnt, tmo_cnt_next;
  logic                   issue_valid_next;
  operation_t             issue_op_next;
  logic                   err_timeout_next;
  logic                   err_unknown_next;

  operation_t             head;
  logic                   flush;
  logic                   push;
  logic                   pop;

  // Handshake and buffer control decode.
  always_comb begin
    head     = buffer[rd_ptr];
    flush    = (state == ST_BR_WAIT) & branch_resolved & branch_taken;
    // Full blocks a push even if a pop frees a slot this cycle.
    in_ready = (count < OCC_W'(DEPTH)) & ~flush;
    push     = in_valid & in_ready;
    pop      = (state == ST_ISSUE) & (count != '0);
  end

  assign occupancy = count;

  // Pointer and occupancy next state; a taken branch empties the buffer.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (push) begin
      wr_ptr_next = wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr + PTR_W'(1);
    end
    if (flush) begin
      // push and pop are both low here, so wr_ptr is stable.
      rd_ptr_next = wr_ptr;
      count_next  = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + OCC_W'(1);
        2'b01:   count_next = count - OCC_W'(1);
        default: count_next = count;
      endcase
    end
  end

  // Issue FSM next state, issue register and sticky error flags.
  always_comb begin
    state_next       = state;
    tmo_cnt_next     = tmo_cnt;
    issue_valid_next = 1'b0;
    issue_op_next    = issue_op;
    err_timeout_next = err_timeout;
    err_unknown_next = err_unknown;
    case (state)
      ST_ISSUE: begin
        if (pop) begin
          case (head.op_type)
            OP_ALU: begin
              issue_valid_next = 1'b1;
              issue_op_next    = head;
            end
            OP_MEM: begin
              issue_valid_next = 1'b1;
              issue_op_next    = head;
              state_next       = ST_MEM_WAIT;
              tmo_cnt_next     = '0;
            end
            OP_BRANCH: begin
              issue_valid_next = 1'b1;
              issue_op_next    = head;
              state_next       = ST_BR_WAIT;
            end
            default: begin
              // Unknown type: consume the entry without issuing it.
              err_unknown_next = 1'b1;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        tmo_cnt_next = tmo_cnt + CNT_W'(1);
        if (mem_done) begin
          state_next = ST_ISSUE;
        end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          err_timeout_next = 1'b1;
          state_next       = ST_ISSUE;
        end
      end
      ST_BR_WAIT: begin
        if (branch_resolved) begin
          state_next = ST_ISSUE;
        end
      end
      default: begin
        state_next = ST_ISSUE;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ISSUE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      issue_valid <= 1'b0;
      issue_op    <= '0;
      err_timeout <= 1'b0;
      err_unknown <= 1'b0;
    end else begin
      state       <= state_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      tmo_cnt     <= tmo_cnt_next;
      issue_valid <= issue_valid_next;
      issue_op    <= issue_op_next;
      err_timeout <= err_timeout_next;
      err_unknown <= err_unknown_next;
    end
  end

  // Buffer storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buffer[wr_ptr] <= in_op;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with DEPTH=4 and a short MEM_TIMEOUT of 8.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  operation_t in_op;
  logic       issue_valid;
  operation_t issue_op;
  logic       mem_done;
  logic       branch_resolved;
  logic       branch_taken;
  logic [2:0] occupancy;
  logic       err_timeout;
  logic       err_unknown;

  int n_checks = 0;
  int n_fail   = 0;
  operation_t issued [$];

  issue_scheduler #(
    .DEPTH       (4),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .issue_valid     (issue_valid),
    .issue_op        (issue_op),
    .mem_done        (mem_done),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .occupancy       (occupancy),
    .err_timeout     (err_timeout),
    .err_unknown     (err_unknown)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every issued op, sampled mid-cycle.
  always @(negedge clk) begin
    if (issue_valid) issued.push_back(issue_op);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic operation_t mk(input logic [1:0] t, input logic [13:0] p);
    operation_t o;
    o.op_type = t;
    o.payload = p;
    return o;
  endfunction

  task automatic idle_and_clear();
    repeat (3) step();
    issued.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0;
    mem_done = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_iv", 32'(issue_valid), 0);
    check("rst_op", 32'(issue_op), 0);
    check("rst_errt", 32'(err_timeout), 0);
    check("rst_erru", 32'(err_unknown), 0);
    check("rst_rdy", 32'(in_ready), 1);

    // 1: three back-to-back ALU ops
    in_valid = 1'b1; in_op = mk(OP_ALU, 14'h011);
    step();
    check("t1_occ1", 32'(occupancy), 1);
    check("t1_iv0", 32'(issue_valid), 0);
    in_op = mk(OP_ALU, 14'h012);
    step();
    check("t1_iv_a", 32'(issue_valid), 1);
    check("t1_op_a", 32'(issue_op), 32'(mk(OP_ALU, 14'h011)));
    in_op = mk(OP_ALU, 14'h013);
    step();
    in_valid = 1'b0;
    check("t1_iv_b", 32'(issue_valid), 1);
    check("t1_op_b", 32'(issue_op), 32'(mk(OP_ALU, 14'h012)));
    step();
    check("t1_iv_c", 32'(issue_valid), 1);
    check("t1_op_c", 32'(issue_op), 32'(mk(OP_ALU, 14'h013)));
    check("t1_occ0", 32'(occupancy), 0);
    step();
    check("t1_iv_end", 32'(issue_valid), 0);

    // 2: MEM then ALU, mem_done after 5 wait cycles
    idle_and_clear();
    in_valid = 1'b1; in_op = mk(OP_MEM, 14'h020);
    step();
    in_op = mk(OP_ALU, 14'h021);
    step();
    in_valid = 1'b0;
    check("t2_iv_mem", 32'(issue_valid), 1);
    check("t2_op_mem", 32'(issue_op), 32'(mk(OP_MEM, 14'h020)));
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_stall", 32'(issue_valid), 0);
    end
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check("t2_bubble", 32'(issue_valid), 0);
    check("t2_occ", 32'(occupancy), 1);
    step();
    check("t2_iv_alu", 32'(issue_valid), 1);
    check("t2_op_alu", 32'(issue_op), 32'(mk(OP_ALU, 14'h021)));
    check("t2_errt", 32'(err_timeout), 0);

    // 3: MEM with no completion times out after 8 wait cycles
    idle_and_clear();
    in_valid = 1'b1; in_op = mk(OP_MEM, 14'h030);
    step();
    in_valid = 1'b0;
    step();
    check("t3_iv_mem", 32'(issue_valid), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("t3_no_err", 32'(err_timeout), 0);
    end
    step();
    check("t3_err", 32'(err_timeout), 1);
    in_valid = 1'b1; in_op = mk(OP_ALU, 14'h031);
    step();
    in_valid = 1'b0;
    step();
    check("t3_iv_alu", 32'(issue_valid), 1);
    check("t3_op_alu", 32'(issue_op), 32'(mk(OP_ALU, 14'h031)));
    check("t3_sticky", 32'(err_timeout), 1);

    // 4: taken branch flushes three younger ALU ops
    idle_and_clear();
    in_valid = 1'b1; in_op = mk(OP_BRANCH, 14'h040);
    step();
    in_op = mk(OP_ALU, 14'h041);
    step();
    check("t4_iv_br", 32'(issue_valid), 1);
    in_op = mk(OP_ALU, 14'h042);
    step();
    in_op = mk(OP_ALU, 14'h043);
    step();
    in_valid = 1'b0;
    check("t4_occ3", 32'(occupancy), 3);
    check("t4_rdy_pre", 32'(in_ready), 1);
    branch_resolved = 1'b1; branch_taken = 1'b1;
    in_valid = 1'b1; in_op = mk(OP_ALU, 14'h044);
    #1;
    check("t4_rdy_flush", 32'(in_ready), 0);
    step();
    branch_resolved = 1'b0; branch_taken = 1'b0; in_valid = 1'b0;
    #1;
    check("t4_occ0", 32'(occupancy), 0);
    check("t4_rdy_post", 32'(in_ready), 1);
    repeat (3) step();
    check("t4_n_issued", 32'(issued.size()), 1);
    check("t4_occ_end", 32'(occupancy), 0);

    // 5: not-taken branch, buffer filled while stalled
    idle_and_clear();
    in_valid = 1'b1; in_op = mk(OP_BRANCH, 14'h050);
    step();
    in_op = mk(OP_ALU, 14'h051);
    step();
    in_op = mk(OP_ALU, 14'h052);
    step();
    in_op = mk(OP_ALU, 14'h053);
    step();
    in_op = mk(OP_ALU, 14'h054);
    step();
    check("t5_occ_full", 32'(occupancy), 4);
    check("t5_rdy_full", 32'(in_ready), 0);
    in_op = mk(OP_ALU, 14'h055);
    step();
    in_valid = 1'b0;
    check("t5_no_push", 32'(occupancy), 4);
    branch_resolved = 1'b1; branch_taken = 1'b0;
    step();
    branch_resolved = 1'b0;
    check("t5_bubble", 32'(issue_valid), 0);
    check("t5_occ_kept", 32'(occupancy), 4);
    step();
    check("t5_iv_first", 32'(issue_valid), 1);
    check("t5_occ3", 32'(occupancy), 3);
    repeat (4) step();
    check("t5_n_issued", 32'(issued.size()), 5);
    if (issued.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        check("t5_order", 32'(issued[i]), 32'(mk(OP_ALU, 14'(14'h050 + i))));
      end
    end

    // 6: unknown type dropped, then reset in the middle of BR_WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_errt_clr", 32'(err_timeout), 0);
    idle_and_clear();
    in_valid = 1'b1; in_op = mk(OP_ALU, 14'h061);
    step();
    in_op = mk(2'd3, 14'h062);
    step();
    in_op = mk(OP_ALU, 14'h063);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("t6_erru", 32'(err_unknown), 1);
    check("t6_n_issued", 32'(issued.size()), 2);
    if (issued.size() == 2) begin
      check("t6_first", 32'(issued[0]), 32'(mk(OP_ALU, 14'h061)));
      check("t6_second", 32'(issued[1]), 32'(mk(OP_ALU, 14'h063)));
    end
    in_valid = 1'b1; in_op = mk(OP_BRANCH, 14'h064);
    step();
    in_op = mk(OP_ALU, 14'h065);
    step();
    in_valid = 1'b0;
    check("t6_occ_pre", 32'(occupancy), 1);
    rst = 1'b1; branch_resolved = 1'b1; branch_taken = 1'b1; mem_done = 1'b1;
    step();
    rst = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0; mem_done = 1'b0;
    #1;
    check("t6_occ_rst", 32'(occupancy), 0);
    check("t6_iv_rst", 32'(issue_valid), 0);
    check("t6_op_rst", 32'(issue_op), 0);
    check("t6_erru_rst", 32'(err_unknown), 0);
    check("t6_rdy_rst", 32'(in_ready), 1);
    in_valid = 1'b1; in_op = mk(OP_ALU, 14'h066);
    step();
    in_valid = 1'b0;
    step();
    check("t6_iv_post", 32'(issue_valid), 1);
    check("t6_op_post", 32'(issue_op), 32'(mk(OP_ALU, 14'h066)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
